// File: rtl/bios_copier_pkg.sv
// Shared definitions for the boot RAM copy engine: FSM states, boot RAM
// geometry, main-memory bus widths and the write payload record.
package bios_copier_pkg;

  localparam int unsigned BOOT_RAM_DEPTH = 128;
  localparam int unsigned BOOT_RAM_AW    = 20;
  localparam int unsigned BOOT_RAM_DW    = 48;
  localparam int unsigned IDX_W          = $clog2(BOOT_RAM_DEPTH);
  localparam int unsigned MEM_AW         = 32;
  localparam int unsigned MEM_DW         = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    WRITE,
    DONE
  } state_e;

  // One main-memory write beat, held constant while the request is pending.
  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] data;
  } mem_wr_t;

endpackage

// File: rtl/bios_copier_if.sv
// Main-memory write handshake between the copy engine and the memory.
//   mem_req   : write request (master -> slave)
//   mem_addr  : byte address   (master -> slave)
//   mem_wdata : write data     (master -> slave)
//   mem_ack   : write accepted this cycle (slave -> master)
interface bios_copier_if;
  import bios_copier_pkg::*;

  logic              mem_req;
  logic [MEM_AW-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_wdata;
  logic              mem_ack;

  modport master (output mem_req, output mem_addr, output mem_wdata, input mem_ack);
  modport slave  (input mem_req, input mem_addr, input mem_wdata, output mem_ack);

endinterface

// File: rtl/bios_copier.sv
// Boot-time copy engine: reads WORDS consecutive words from the boot RAM,
// writes each to main memory at DST_BASE + 4*index, accumulates an XOR
// checksum, and holds the CPU in reset until the first copy completes.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : single-cycle pulse, honoured in IDLE or DONE only
//   rom_addr   : boot RAM word address (upper bits always zero)
//   rom_we     : boot RAM write enable, constantly 0
//   rom_dout   : boot RAM read data, one cycle after rom_addr; [47:32] unused
//   mem        : main-memory write handshake (master side)
//   busy       : copy in progress (decoded from state)
//   done       : sticky completion flag, cleared by the next start
//   checksum   : XOR of all copied words
//   cpu_rst_n  : CPU reset release, set by the first completed copy
module bios_copier
  import bios_copier_pkg::*;
#(
  parameter int unsigned WORDS    = 128,
  parameter logic [31:0] DST_BASE = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [BOOT_RAM_AW-1:0] rom_addr,
  output logic                   rom_we,
  input  logic [BOOT_RAM_DW-1:0] rom_dout,
  bios_copier_if.master          mem,
  output logic                   busy,
  output logic                   done,
  output logic [MEM_DW-1:0]      checksum,
  output logic                   cpu_rst_n
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  mem_wr_t           wr_q, wr_d;
  logic [MEM_DW-1:0] cs_q, cs_d;
  logic              done_q, done_d;
  logic              cpu_q, cpu_d;

  // Upper read-port bits carry nothing for this engine.
  logic unused_rom_hi;
  assign unused_rom_hi = ^rom_dout[BOOT_RAM_DW-1:MEM_DW];

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wr_q    <= '0;
      cs_q    <= '0;
      done_q  <= 1'b0;
      cpu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
      cpu_q   <= cpu_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    cs_d    = cs_q;
    done_d  = done_q;
    cpu_d   = cpu_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d   = '0;
          cs_d    = '0;
          done_d  = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        wr_d.data = rom_dout[MEM_DW-1:0];
        wr_d.addr = DST_BASE + (MEM_AW'(idx_q) << 2);
        cs_d      = cs_q ^ rom_dout[MEM_DW-1:0];
        state_d   = WRITE;
      end
      WRITE: begin
        if (mem.mem_ack) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            cpu_d   = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ISSUE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rom_addr      = BOOT_RAM_AW'(idx_q);
  assign rom_we        = 1'b0;
  assign mem.mem_req   = (state_q == WRITE);
  assign mem.mem_addr  = wr_q.addr;
  assign mem.mem_wdata = wr_q.data;
  assign busy          = (state_q == ISSUE) || (state_q == CAPTURE) || (state_q == WRITE);
  assign done          = done_q;
  assign checksum      = cs_q;
  assign cpu_rst_n     = cpu_q;

endmodule
